mem_stage: RTL and testbench

- Memory-access stage of the 19-bit pipelined SoC core.
- Holds a synchronous data RAM.
- Decodes two memory-mapped accelerator windows, FFT and crypto, and latches operand/config registers for them.
- Emits one-cycle start strobes (fft_key, crypto_key) to the accelerators.

---
 rtl/mem_stage.sv | 164 ++++++++++++++++
 tb/tb_mem_stage.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the 19-bit pipelined core.
//   Holds a synchronous data RAM and decodes two 4K-word accelerator windows
//   (crypto at CRYPTO_BASE, FFT at FFT_BASE) whose operand/config registers
//   are latched here. The stage emits one-cycle start strobes to the
//   accelerators.
// Optional feature: define READ_BYPASS_EN for write-first reads. Without it,
//   a read in the same cycle as a write/start returns the old value.
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   addr       in   word address from EX
//   write_data in   store data / accelerator config word
//   fft_strt   in   FFT start request
//   crypto_en  in   crypto start request
//   rs1_data   in   source operand 1
//   rs2_data   in   source operand 2
//   rd_data    in   destination tag forwarded to FFT
//   mem_write  in   store enable
//   mem_read   in   load enable
//   read_data  out  registered load result (1-cycle latency, holds otherwise)
//   fft_key    out  one-cycle FFT start strobe
//   crypto_key out  one-cycle crypto start strobe
module mem_stage #(
  parameter int unsigned DEPTH       = 1024,
  parameter logic [18:0] CRYPTO_BASE = 19'h06000,
  parameter logic [18:0] FFT_BASE    = 19'h7F000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [18:0] addr,
  input  logic [18:0] write_data,
  input  logic        fft_strt,
  input  logic        crypto_en,
  input  logic [18:0] rs1_data,
  input  logic [18:0] rs2_data,
  input  logic [18:0] rd_data,
  input  logic        mem_write,
  input  logic        mem_read,
  output logic [18:0] read_data,
  output logic        fft_key,
  output logic        crypto_key
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [18:0] ram_q [DEPTH];

  logic [AW-1:0] idx;
  logic [1:0]    off;
  logic          in_ram, in_cry, in_fft;

  logic [18:0] key_q, key_d, res_q, res_d;
  logic [18:0] cfg_q, cfg_d, fa_q, fa_d, fb_q, fb_d, tag_q, tag_d;
  logic [18:0] read_data_q, rd_src;
  logic        fft_key_q, crypto_key_q;
  logic        ram_we, cry_go, fft_go;

  assign idx    = addr[AW-1:0];
  assign off    = addr[1:0];
  assign in_ram = (addr < CRYPTO_BASE);
  assign in_cry = (addr[18:12] == CRYPTO_BASE[18:12]);
  assign in_fft = (addr[18:12] == FFT_BASE[18:12]);
  assign cry_go = crypto_en & in_cry;
  assign fft_go = fft_strt & in_fft;

  // Next-state of the accelerator registers. A start and a mem_write that hit
  // the same register both deliver write_data, so their order is irrelevant.
  always_comb begin
    ram_we = mem_write & in_ram;
    key_d  = key_q;
    res_d  = res_q;
    cfg_d  = cfg_q;
    fa_d   = fa_q;
    fb_d   = fb_q;
    tag_d  = tag_q;
    if (mem_write && in_cry && off == 2'd0) key_d = write_data;
    if (mem_write && in_fft && off == 2'd0) cfg_d = write_data;
    if (cry_go) begin
      key_d = write_data;
      res_d = rs1_data ^ write_data;
    end
    if (fft_go) begin
      cfg_d = write_data;
      fa_d  = rs1_data;
      fb_d  = rs2_data;
      tag_d = rd_data;
    end
  end

  // Read source mux. Write-first reads look at the next-state values, which
  // covers both mem_write and start-triggered updates uniformly.
  always_comb begin
    rd_src = '0;
`ifdef READ_BYPASS_EN
    if (in_ram) begin
      rd_src = ram_we ? write_data : ram_q[idx];
    end else if (in_cry) begin
      case (off)
        2'd0:    rd_src = key_d;
        2'd1:    rd_src = res_d;
        default: rd_src = '0;
      endcase
    end else if (in_fft) begin
      case (off)
        2'd0:    rd_src = cfg_d;
        2'd1:    rd_src = fa_d;
        2'd2:    rd_src = fb_d;
        default: rd_src = tag_d;
      endcase
    end
`else
    if (in_ram) begin
      rd_src = ram_q[idx];
    end else if (in_cry) begin
      case (off)
        2'd0:    rd_src = key_q;
        2'd1:    rd_src = res_q;
        default: rd_src = '0;
      endcase
    end else if (in_fft) begin
      case (off)
        2'd0:    rd_src = cfg_q;
        2'd1:    rd_src = fa_q;
        2'd2:    rd_src = fb_q;
        default: rd_src = tag_q;
      endcase
    end
`endif
  end

  // RAM contents survive reset; reset only blocks a simultaneous store.
  always_ff @(posedge clk) begin
    if (!rst && ram_we) ram_q[idx] <= write_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      read_data_q  <= '0;
      fft_key_q    <= 1'b0;
      crypto_key_q <= 1'b0;
      key_q        <= '0;
      res_q        <= '0;
      cfg_q        <= '0;
      fa_q         <= '0;
      fb_q         <= '0;
      tag_q        <= '0;
    end else begin
      if (mem_read) read_data_q <= rd_src;
      fft_key_q    <= fft_go;
      crypto_key_q <= cry_go;
      key_q        <= key_d;
      res_q        <= res_d;
      cfg_q        <= cfg_d;
      fa_q         <= fa_d;
      fb_q         <= fb_d;
      tag_q        <= tag_d;
    end
  end

  assign read_data  = read_data_q;
  assign fft_key    = fft_key_q;
  assign crypto_key = crypto_key_q;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [18:0] addr, write_data, rs1_data, rs2_data, rd_data;
  logic        fft_strt, crypto_en, mem_write, mem_read;
  logic [18:0] read_data;
  logic        fft_key, crypto_key;

  mem_stage #(.DEPTH(1024), .CRYPTO_BASE(19'h06000), .FFT_BASE(19'h7F000)) dut (
    .clk(clk), .rst(rst), .addr(addr), .write_data(write_data),
    .fft_strt(fft_strt), .crypto_en(crypto_en), .rs1_data(rs1_data),
    .rs2_data(rs2_data), .rd_data(rd_data), .mem_write(mem_write),
    .mem_read(mem_read), .read_data(read_data), .fft_key(fft_key),
    .crypto_key(crypto_key)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  bit chk_en = 0;

  task automatic check(input string name, input logic [18:0] act, input logic [18:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: a memory map with word array and two register files.
  localparam int CB = 'h06000;
  localparam int FB = 'h7F000;
  bit [18:0] m_ram [1024];
  bit [18:0] m_cry [2];   // key, result
  bit [18:0] m_fft [4];   // cfg, a, b, tag
  bit [18:0] e_rd;
  bit        e_fk, e_ck;

  function automatic bit [18:0] lookup(input int a);
    if (a < CB) return m_ram[a % 1024];
    if (a >= CB && a < CB + 4096) return (a % 4 < 2) ? m_cry[a % 4] : 19'd0;
    if (a >= FB && a < FB + 4096) return m_fft[a % 4];
    return 19'd0;
  endfunction

  always @(posedge clk) begin
    int a;
    bit [18:0] v;
    a = int'(addr);
    if (rst) begin
      e_rd = 0; e_fk = 0; e_ck = 0;
      m_cry = '{default: 0};
      m_fft = '{default: 0};
    end else begin
      v = lookup(a);
      if (mem_write) begin
        if (a < CB) m_ram[a % 1024] = write_data;
        else if (a >= CB && a < CB + 4096 && a % 4 == 0) m_cry[0] = write_data;
        else if (a >= FB && a < FB + 4096 && a % 4 == 0) m_fft[0] = write_data;
      end
      e_ck = crypto_en && a >= CB && a < CB + 4096;
      if (e_ck) begin
        m_cry[0] = write_data;
        m_cry[1] = rs1_data ^ write_data;
      end
      e_fk = fft_strt && a >= FB && a < FB + 4096;
      if (e_fk) begin
        m_fft[0] = write_data; m_fft[1] = rs1_data;
        m_fft[2] = rs2_data;   m_fft[3] = rd_data;
      end
`ifdef READ_BYPASS_EN
      v = lookup(a);
`endif
      if (mem_read) e_rd = v;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_read_data", read_data, e_rd);
      check("model_fft_key", {18'd0, fft_key}, {18'd0, e_fk});
      check("model_crypto_key", {18'd0, crypto_key}, {18'd0, e_ck});
    end
  end

  task automatic tick(input bit r, input logic [18:0] a, input logic [18:0] wd,
                      input bit fs, input bit ce, input logic [18:0] r1,
                      input logic [18:0] r2, input logic [18:0] rdv,
                      input bit mw, input bit mr);
    rst = r; addr = a; write_data = wd; fft_strt = fs; crypto_en = ce;
    rs1_data = r1; rs2_data = r2; rd_data = rdv; mem_write = mw; mem_read = mr;
    @(negedge clk);
  endtask

  task automatic rd(input logic [18:0] a);
    tick(0, a, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    rst = 1; addr = 0; write_data = 0; fft_strt = 0; crypto_en = 0;
    rs1_data = 0; rs2_data = 0; rd_data = 0; mem_write = 0; mem_read = 0;
    @(negedge clk);
    tick(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk_en = 1;
    check("reset_read_data", read_data, 19'd0);
    check("reset_fft_key", {18'd0, fft_key}, 19'd0);
    check("reset_crypto_key", {18'd0, crypto_key}, 19'd0);

    // RAM round trip
    tick(0, 19'h100, 19'd123, 0, 0, 0, 0, 0, 1, 0);
    rd(19'h100);
    check("ram_roundtrip", read_data, 19'd123);
    check("ram_no_fft_key", {18'd0, fft_key}, 19'd0);

    // FFT start
    tick(0, 19'h7F000, 19'd138, 1, 0, 19'd5, 19'd6, 19'd7, 0, 0);
    check("fft_key_pulse", {18'd0, fft_key}, 19'd1);
    rd(19'h7F000);
    check("fft_key_drop", {18'd0, fft_key}, 19'd0);
    check("fft_cfg", read_data, 19'd138);
    rd(19'h7F001); check("fft_a", read_data, 19'd5);
    rd(19'h7F002); check("fft_b", read_data, 19'd6);
    rd(19'h7F003); check("fft_tag", read_data, 19'd7);

    // Crypto start
    tick(0, 19'h06000, 19'd255, 0, 1, 19'h0F0, 0, 0, 0, 0);
    check("crypto_key_pulse", {18'd0, crypto_key}, 19'd1);
    rd(19'h06000);
    check("crypto_key_drop", {18'd0, crypto_key}, 19'd0);
    check("crypto_key_reg", read_data, 19'd255);
    rd(19'h06001); check("crypto_res", read_data, 19'h00F);
    rd(19'h06002); check("crypto_off2_zero", read_data, 19'd0);

    // Out-of-window starts are ignored
    tick(0, 19'h100, 19'd999, 1, 0, 19'd11, 19'd12, 19'd13, 0, 0);
    check("oow_fft_key", {18'd0, fft_key}, 19'd0);
    tick(0, 19'h7F000, 19'd77, 0, 1, 19'd3, 0, 0, 0, 0);
    check("oow_crypto_key", {18'd0, crypto_key}, 19'd0);
    rd(19'h7F001); check("oow_fft_a_kept", read_data, 19'd5);
    rd(19'h06000); check("oow_key_kept", read_data, 19'd255);
    rd(19'h100);   check("oow_ram_kept", read_data, 19'd123);

    // Same-cycle read/write
    tick(0, 19'h100, 19'd9, 0, 0, 0, 0, 0, 1, 1);
`ifdef READ_BYPASS_EN
    check("rw_same_cycle", read_data, 19'd9);
`else
    check("rw_same_cycle", read_data, 19'd123);
`endif
    rd(19'h100);   check("rw_after", read_data, 19'd9);
    rd(19'h10000); check("unmapped_read", read_data, 19'd0);

    // FFT start with simultaneous read of fft_a
    tick(0, 19'h7F001, 19'd200, 1, 0, 19'd40, 19'd41, 19'd42, 0, 1);
`ifdef READ_BYPASS_EN
    check("start_read_same_cycle", read_data, 19'd40);
`else
    check("start_read_same_cycle", read_data, 19'd5);
`endif

    // mem_write to registers: offset 0 only
    tick(0, 19'h06000, 19'd31, 0, 0, 0, 0, 0, 1, 0);
    tick(0, 19'h06001, 19'd32, 0, 0, 0, 0, 0, 1, 0);
    rd(19'h06000); check("key_mem_write", read_data, 19'd31);
    rd(19'h06001); check("res_write_ignored", read_data, 19'h00F);

    // Reset mid-operation
    tick(0, 19'h100, 19'd123, 0, 0, 0, 0, 0, 1, 0);
    tick(1, 19'h7F000, 19'd50, 1, 0, 19'd1, 19'd2, 19'd3, 0, 1);
    check("rst_fft_key", {18'd0, fft_key}, 19'd0);
    check("rst_read_data", read_data, 19'd0);
    rd(19'h7F000); check("rst_fft_cfg", read_data, 19'd0);
    rd(19'h100);   check("rst_ram_kept", read_data, 19'd123);

    // Aliasing and RAM boundary
    tick(0, 19'h500, 19'd44, 0, 0, 0, 0, 0, 1, 0);
    rd(19'h100);   check("alias_modulo", read_data, 19'd44);
    tick(0, 19'h05FFF, 19'd321, 0, 0, 0, 0, 0, 1, 0);
    rd(19'h003FF); check("ram_top_alias", read_data, 19'd321);
    tick(0, 19'h10100, 19'd77, 0, 0, 0, 0, 0, 1, 0);
    rd(19'h100);   check("unmapped_write_ignored", read_data, 19'd44);

    // Held crypto_en pulses every cycle
    tick(0, 19'h06FFC, 19'd5, 0, 1, 19'd1, 0, 0, 0, 0);
    check("crypto_hold_1", {18'd0, crypto_key}, 19'd1);
    tick(0, 19'h06FFC, 19'd6, 0, 1, 19'd1, 0, 0, 0, 0);
    check("crypto_hold_2", {18'd0, crypto_key}, 19'd1);
    rd(19'h06001); check("crypto_res_last", read_data, 19'd7);

    chk_en = 0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
